xt_mem_bridge: RTL and testbench

Parametrised 8088-bus-to-SDRAM-controller bridge, successor to the fixed XT RAM block. It decodes conventional RAM from a 16-segment reserve mask and maps an EMS page frame of up to four 16 KB windows. Each byte access becomes one 16-bit word request with byte enables. Optional one-deep write posting releases the CPU before the SDRAM write completes. It sits between the bus arbiter's internal bus and the SDRAM controller's request/ack port.

---
 rtl/xt_mem_bridge.sv | 108 ++++++++++
 tb/tb_xt_mem_bridge.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xt_mem_bridge.sv
// 8088 bus to SDRAM controller bridge: conventional RAM / EMS frame decode,
// one 16-bit word request per byte access, optional one-deep write posting.
module xt_mem_bridge #(
  parameter int unsigned PAGE_BITS     = 7,
  parameter int unsigned EMS_PAGES     = 4,
  parameter logic [15:0] RESERVED_MASK = 16'h8800,
  parameter bit          POST_WRITES   = 1'b1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enable_sdram,
  input  logic [19:0]              address,
  input  logic [7:0]               internal_data_bus,
  output logic [7:0]               data_bus_out,
  input  logic                     memory_read_n,
  input  logic                     memory_write_n,
  output logic                     memory_access_ready,
  output logic                     ram_address_select_n,
  input  logic                     ems_enable,
  input  logic [3:0]               ems_frame,
  input  logic [4*PAGE_BITS-1:0]   map_ems,
  output logic [PAGE_BITS+13:0]    mem_address,
  output logic [15:0]              mem_write_data,
  output logic [1:0]               mem_byte_enable,
  output logic                     mem_write_req,
  output logic                     mem_read_req,
  input  logic                     mem_ack,
  input  logic [15:0]              mem_read_data
);
  localparam int unsigned PA_W = PAGE_BITS + 15;

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;
  state_t state, state_next;

  logic                 served;
  logic [1:0]           window;
  logic [PAGE_BITS-1:0] ems_page;
  logic                 ems_hit, selected, strobe, is_write, start;
  logic [PA_W-1:0]      phys;

  assign window = address[15:14];

  always_comb begin
    ems_page = '0;
    for (int unsigned i = 0; i < 4; i++)
      if (window == i[1:0]) ems_page = map_ems[i*PAGE_BITS +: PAGE_BITS];
  end

  assign ems_hit = ems_enable && (address[19:16] == ems_frame) && ({30'd0, window} < EMS_PAGES);

  always_comb begin
    phys = '0;
    if (ems_hit) phys = {1'b1, ems_page, address[13:0]};
    else         phys[19:0] = address;
  end

  // An EMS hit overrides the reserved-segment mask.
  assign selected             = enable_sdram & (ems_hit | ~RESERVED_MASK[address[19:16]]);
  assign ram_address_select_n = ~selected;
  assign strobe               = ~memory_read_n | ~memory_write_n;
  assign is_write             = ~memory_write_n;
  assign start                = selected & strobe & ~served & (state == IDLE);
  assign memory_access_ready  = ~(selected & strobe) | served;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:        if (start) state_next = is_write ? WRITE : READ;
      READ, WRITE: if (mem_ack) state_next = IDLE;
      default:     state_next = IDLE;
    endcase
  end

  always_comb begin
    mem_read_req  = (state == READ);
    mem_write_req = (state == WRITE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      served          <= 1'b0;
      mem_address     <= '0;
      mem_write_data  <= '0;
      mem_byte_enable <= '0;
      data_bus_out    <= '0;
    end else begin
      if (start) begin
        mem_address     <= phys[PA_W-1:1];
        mem_byte_enable <= address[0] ? 2'b10 : 2'b01;
        if (is_write) mem_write_data <= {internal_data_bus, internal_data_bus};
      end
      if (state == READ && mem_ack)
        data_bus_out <= address[0] ? mem_read_data[15:8] : mem_read_data[7:0];
      // served only latches while a strobe is held, so an abandoned cycle completes silently
      if (!strobe)
        served <= 1'b0;
      else if (start && is_write && POST_WRITES)
        served <= 1'b1;
      else if (mem_ack && (state == READ || (state == WRITE && !POST_WRITES)))
        served <= 1'b1;
    end
  end
endmodule

// File: tb/tb_xt_mem_bridge.sv
// Bench for xt_mem_bridge: behavioural SDRAM controller with random ack latency,
// CPU-level reference memory, directed scenarios plus randomized accesses.
module tb_xt_mem_bridge;
  logic        clock, reset, enable_sdram;
  logic [19:0] address;
  logic [7:0]  internal_data_bus, data_bus_out;
  logic        memory_read_n, memory_write_n, memory_access_ready, ram_address_select_n;
  logic        ems_enable;
  logic [3:0]  ems_frame;
  logic [27:0] map_ems;
  logic [20:0] mem_address;
  logic [15:0] mem_write_data, mem_read_data;
  logic [1:0]  mem_byte_enable;
  logic        mem_write_req, mem_read_req, mem_ack;

  logic [7:0]  np_data_bus_out;
  logic        np_rd_n, np_wr_n, np_ready, np_sel_n, np_wr_req, np_rd_req, np_ack;
  logic [20:0] np_mem_address;
  logic [15:0] np_wd, np_rdata;
  logic [1:0]  np_be;

  int n_chk = 0;
  int n_fail = 0;

  xt_mem_bridge dut (
    .clock(clock), .reset(reset), .enable_sdram(enable_sdram), .address(address),
    .internal_data_bus(internal_data_bus), .data_bus_out(data_bus_out),
    .memory_read_n(memory_read_n), .memory_write_n(memory_write_n),
    .memory_access_ready(memory_access_ready), .ram_address_select_n(ram_address_select_n),
    .ems_enable(ems_enable), .ems_frame(ems_frame), .map_ems(map_ems),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_byte_enable(mem_byte_enable), .mem_write_req(mem_write_req),
    .mem_read_req(mem_read_req), .mem_ack(mem_ack), .mem_read_data(mem_read_data));

  xt_mem_bridge #(.RESERVED_MASK(16'h0000), .POST_WRITES(1'b0)) dut_np (
    .clock(clock), .reset(reset), .enable_sdram(enable_sdram), .address(address),
    .internal_data_bus(internal_data_bus), .data_bus_out(np_data_bus_out),
    .memory_read_n(np_rd_n), .memory_write_n(np_wr_n),
    .memory_access_ready(np_ready), .ram_address_select_n(np_sel_n),
    .ems_enable(ems_enable), .ems_frame(ems_frame), .map_ems(map_ems),
    .mem_address(np_mem_address), .mem_write_data(np_wd),
    .mem_byte_enable(np_be), .mem_write_req(np_wr_req),
    .mem_read_req(np_rd_req), .mem_ack(np_ack), .mem_read_data(np_rdata));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct { bit wr; logic [20:0] addr; logic [1:0] be; logic [15:0] wd; } req_t;
  req_t       log_q[$];
  logic [7:0] sdram   [logic [21:0]];
  logic [7:0] ref_mem [logic [21:0]];
  bit         ctl_on = 1'b1;
  int         ctl_delay = 0;
  int         wait_cnt = -1;
  req_t       ctl_r;
  logic [21:0] ctl_base;

  function automatic logic [7:0] init_byte(input logic [21:0] p);
    return p[7:0] ^ p[15:8] ^ {2'b00, p[21:16]} ^ 8'hC3;
  endfunction
  function automatic logic [7:0] sd_byte(input logic [21:0] p);
    return sdram.exists(p) ? sdram[p] : init_byte(p);
  endfunction
  function automatic logic [7:0] ref_byte(input logic [21:0] p);
    return ref_mem.exists(p) ? ref_mem[p] : init_byte(p);
  endfunction

  // Physical byte address from the decode rules, in plain arithmetic.
  function automatic logic [21:0] exp_phys(input logic [19:0] a);
    int unsigned win, page;
    win = a[15:14];
    if (ems_enable && a[19:16] == ems_frame && win < 4) begin
      page = 32'(map_ems >> (win * 7)) & 32'h7F;
      return 22'(32'h200000 + page * 32'h4000 + 32'(a[13:0]));
    end
    return 22'(a);
  endfunction

  // Behavioural SDRAM controller: ack after ctl_delay (or random) cycles.
  initial begin
    mem_ack = 1'b0;
    mem_read_data = '0;
    forever begin
      @(negedge clock);
      if (ctl_on) begin
        mem_ack = 1'b0;
        if (reset) wait_cnt = -1;
        else if (mem_read_req || mem_write_req) begin
          if (wait_cnt < 0) wait_cnt = (ctl_delay >= 0) ? ctl_delay : int'($urandom_range(0, 3));
          if (wait_cnt == 0) begin
            ctl_r.wr = mem_write_req; ctl_r.addr = mem_address;
            ctl_r.be = mem_byte_enable; ctl_r.wd = mem_write_data;
            log_q.push_back(ctl_r);
            ctl_base = {mem_address, 1'b0};
            if (ctl_r.wr) begin
              if (ctl_r.be[0]) sdram[ctl_base]      = ctl_r.wd[7:0];
              if (ctl_r.be[1]) sdram[ctl_base + 1]  = ctl_r.wd[15:8];
            end else
              mem_read_data = {sd_byte(ctl_base + 1), sd_byte(ctl_base)};
            mem_ack = 1'b1;
            wait_cnt = -1;
          end else wait_cnt--;
        end
      end
    end
  end

  task automatic wait_ready(input int bound, output int cycles, output bit ok);
    ok = 1'b0; cycles = 0;
    while (cycles < bound && !ok) begin
      @(negedge clock); cycles++;
      if (memory_access_ready === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic wait_idle(input int bound, output bit ok);
    int c = 0;
    ok = 1'b0;
    while (c < bound && !ok) begin
      @(negedge clock); c++;
      if (mem_read_req === 1'b0 && mem_write_req === 1'b0) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    n_chk++; if (memory_access_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b want 1", memory_access_ready); end
    n_chk++; if ({mem_read_req, mem_write_req} !== 2'b00) begin n_fail++; $display("FAIL rst_req: got %b want 00", {mem_read_req, mem_write_req}); end
    n_chk++; if (mem_address !== 21'h0) begin n_fail++; $display("FAIL rst_addr: got %h want 0", mem_address); end
    n_chk++; if ({mem_byte_enable, mem_write_data} !== 18'h0) begin n_fail++; $display("FAIL rst_be_wd: got %h want 0", {mem_byte_enable, mem_write_data}); end
    n_chk++; if (data_bus_out !== 8'h00) begin n_fail++; $display("FAIL rst_dout: got %h want 00", data_bus_out); end
    n_chk++; if (np_wr_req !== 1'b0) begin n_fail++; $display("FAIL rst_np_req: got %b want 0", np_wr_req); end
    reset = 1'b0;
  endtask

  task automatic test_conventional_read();
    int cyc; bit ok; logic [21:0] pa;
    @(negedge clock);
    ems_enable = 1'b0; ctl_delay = 3; log_q.delete();
    sdram[22'h12344] = 8'h5A; sdram[22'h12345] = 8'hA5;
    ref_mem[22'h12344] = 8'h5A; ref_mem[22'h12345] = 8'hA5;
    address = 20'h12345; memory_read_n = 1'b0;
    pa = exp_phys(20'h12345);
    @(negedge clock);
    n_chk++; if (mem_read_req !== 1'b1) begin n_fail++; $display("FAIL cr_req: got %b want 1", mem_read_req); end
    n_chk++; if (mem_address !== pa[21:1]) begin n_fail++; $display("FAIL cr_addr: got %h want %h", mem_address, pa[21:1]); end
    n_chk++; if (mem_byte_enable !== 2'b10) begin n_fail++; $display("FAIL cr_be: got %b want 10", mem_byte_enable); end
    n_chk++; if (memory_access_ready !== 1'b0) begin n_fail++; $display("FAIL cr_wait: got %b want 0", memory_access_ready); end
    wait_ready(30, cyc, ok);
    n_chk++; if (!ok || cyc != 4) begin n_fail++; $display("FAIL cr_latency: got ok=%0d cycles=%0d want cycles=4", ok, cyc); end
    n_chk++; if (data_bus_out !== ref_byte(pa)) begin n_fail++; $display("FAIL cr_data: got %h want %h", data_bus_out, ref_byte(pa)); end
    n_chk++; if (mem_read_req !== 1'b0) begin n_fail++; $display("FAIL cr_req_drop: got %b want 0", mem_read_req); end
    memory_read_n = 1'b1;
    @(negedge clock);
    n_chk++; if (data_bus_out !== 8'hA5) begin n_fail++; $display("FAIL cr_hold: got %h want a5", data_bus_out); end
  endtask

  task automatic test_ems();
    int cyc; bit ok; logic [21:0] pa;
    @(negedge clock);
    ems_enable = 1'b1; ems_frame = 4'hD; ctl_delay = 0; log_q.delete();
    map_ems = {7'h33, 7'h15, 7'h0A, 7'h41};
    address = 20'hD8001; memory_read_n = 1'b0;
    pa = exp_phys(20'hD8001);
    #1;
    n_chk++; if (ram_address_select_n !== 1'b0) begin n_fail++; $display("FAIL ems_sel: got %b want 0", ram_address_select_n); end
    @(negedge clock);
    n_chk++; if (mem_address !== pa[21:1]) begin n_fail++; $display("FAIL ems_addr: got %h want %h", mem_address, pa[21:1]); end
    n_chk++; if (mem_byte_enable !== 2'b10) begin n_fail++; $display("FAIL ems_be: got %b want 10", mem_byte_enable); end
    wait_ready(20, cyc, ok);
    n_chk++; if (!ok || data_bus_out !== ref_byte(pa)) begin n_fail++; $display("FAIL ems_data: got %h ok=%0d want %h", data_bus_out, ok, ref_byte(pa)); end
    memory_read_n = 1'b1;
    @(negedge clock);
    ems_frame = 4'hB; address = 20'hB4000;
    #1;
    n_chk++; if (ram_address_select_n !== 1'b0) begin n_fail++; $display("FAIL ems_override: got %b want 0", ram_address_select_n); end
    ems_enable = 1'b0;
    #1;
    n_chk++; if (ram_address_select_n !== 1'b1) begin n_fail++; $display("FAIL ems_off_mask: got %b want 1", ram_address_select_n); end
    ems_frame = 4'hD;
  endtask

  task automatic test_reserved();
    logic [19:0] addrs [2];
    addrs[0] = 20'hB8000; addrs[1] = 20'hF0000;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      ems_enable = 1'b0; address = addrs[i]; memory_read_n = 1'b0;
      #1;
      n_chk++; if (ram_address_select_n !== 1'b1 || memory_access_ready !== 1'b1) begin n_fail++; $display("FAIL rsv_sel_ready %h: got sel_n=%b ready=%b want 1 1", addrs[i], ram_address_select_n, memory_access_ready); end
      n_chk++; if (np_sel_n !== 1'b0) begin n_fail++; $display("FAIL rsv_mask0_sel %h: got %b want 0", addrs[i], np_sel_n); end
      repeat (3) @(negedge clock);
      n_chk++; if (mem_read_req !== 1'b0) begin n_fail++; $display("FAIL rsv_noreq %h: got %b want 0", addrs[i], mem_read_req); end
      memory_read_n = 1'b1;
    end
    @(negedge clock);
    enable_sdram = 1'b0; address = 20'h12345;
    #1;
    n_chk++; if (ram_address_select_n !== 1'b1) begin n_fail++; $display("FAIL rsv_disabled: got %b want 1", ram_address_select_n); end
    enable_sdram = 1'b1;
  endtask

  task automatic test_posted_write();
    int cyc; bit ok;
    @(negedge clock);
    ems_enable = 1'b0; ctl_delay = 10; log_q.delete();
    address = 20'h00010; internal_data_bus = 8'h3C; memory_write_n = 1'b0;
    ref_mem[exp_phys(20'h00010)] = 8'h3C;
    @(negedge clock);
    n_chk++; if (memory_access_ready !== 1'b1) begin n_fail++; $display("FAIL pw_ready: got %b want 1", memory_access_ready); end
    n_chk++; if (mem_write_req !== 1'b1 || mem_write_data !== 16'h3C3C || mem_byte_enable !== 2'b01 || mem_address !== 21'h8) begin
      n_fail++; $display("FAIL pw_req: got req=%b wd=%h be=%b addr=%h want 1 3c3c 01 000008", mem_write_req, mem_write_data, mem_byte_enable, mem_address); end
    memory_write_n = 1'b1;
    @(negedge clock);
    memory_read_n = 1'b0;
    @(negedge clock);
    n_chk++; if (memory_access_ready !== 1'b0 || mem_read_req !== 1'b0 || mem_write_req !== 1'b1) begin
      n_fail++; $display("FAIL pw_hold: got ready=%b rd=%b wr=%b want 0 0 1", memory_access_ready, mem_read_req, mem_write_req); end
    wait_ready(40, cyc, ok);
    n_chk++; if (!ok || data_bus_out !== 8'h3C) begin n_fail++; $display("FAIL pw_readback: got %h ok=%0d want 3c", data_bus_out, ok); end
    n_chk++; if (log_q.size() != 2 || !log_q[0].wr || log_q[1].wr) begin n_fail++; $display("FAIL pw_order: got %0d requests want write then read", log_q.size()); end
    memory_read_n = 1'b1;
  endtask

  task automatic test_nonposted_write();
    @(negedge clock);
    address = 20'h00020; internal_data_bus = 8'h77; np_wr_n = 1'b0;
    @(negedge clock);
    n_chk++; if (np_wr_req !== 1'b1 || np_wd !== 16'h7777 || np_be !== 2'b01 || np_mem_address !== 21'h10) begin
      n_fail++; $display("FAIL np_req: got req=%b wd=%h be=%b addr=%h want 1 7777 01 000010", np_wr_req, np_wd, np_be, np_mem_address); end
    n_chk++; if (np_ready !== 1'b0) begin n_fail++; $display("FAIL np_wait0: got %b want 0", np_ready); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      n_chk++; if (np_ready !== 1'b0) begin n_fail++; $display("FAIL np_wait%0d: got %b want 0", i + 1, np_ready); end
    end
    np_ack = 1'b1;
    @(negedge clock);
    np_ack = 1'b0;
    n_chk++; if (np_ready !== 1'b1 || np_wr_req !== 1'b0) begin n_fail++; $display("FAIL np_done: got ready=%b req=%b want 1 0", np_ready, np_wr_req); end
    np_wr_n = 1'b1;
  endtask

  task automatic test_abort();
    int cyc; bit ok; logic [21:0] pa;
    @(negedge clock);
    ems_enable = 1'b0; ctl_delay = 2; log_q.delete();
    address = 20'h23456; memory_read_n = 1'b0;
    pa = exp_phys(20'h23456);
    @(negedge clock);
    n_chk++; if (mem_read_req !== 1'b1) begin n_fail++; $display("FAIL ab_req: got %b want 1", mem_read_req); end
    memory_read_n = 1'b1;
    wait_idle(20, ok);
    n_chk++; if (!ok || log_q.size() != 1) begin n_fail++; $display("FAIL ab_complete: got ok=%0d requests=%0d want 1 1", ok, log_q.size()); end
    n_chk++; if (data_bus_out !== ref_byte(pa)) begin n_fail++; $display("FAIL ab_data: got %h want %h", data_bus_out, ref_byte(pa)); end
    address = 20'h23459; memory_read_n = 1'b0;
    pa = exp_phys(20'h23459);
    wait_ready(20, cyc, ok);
    n_chk++; if (!ok || cyc < 2 || data_bus_out !== ref_byte(pa)) begin n_fail++; $display("FAIL ab_next: got %h ok=%0d cycles=%0d want %h", data_bus_out, ok, cyc, ref_byte(pa)); end
    memory_read_n = 1'b1;
  endtask

  task automatic test_random();
    int cyc; bit ok, wr; logic [19:0] a; logic [21:0] pa; logic [7:0] d;
    logic [3:0] segs [13];
    for (int i = 0; i < 10; i++) segs[i] = 4'(i);
    segs[10] = 4'hA; segs[11] = 4'hC; segs[12] = 4'hE;
    for (int it = 0; it < 40; it++) begin
      @(negedge clock);
      ctl_delay = -1; log_q.delete();
      ems_enable = 1'b1; ems_frame = 4'hD; map_ems = 28'($urandom);
      if ($urandom_range(0, 2) == 0) a = {4'hD, 16'($urandom)};
      else a = {segs[$urandom_range(0, 12)], 16'($urandom)};
      wr = 1'($urandom_range(0, 1)); d = 8'($urandom);
      pa = exp_phys(a);
      address = a;
      if (wr) begin internal_data_bus = d; memory_write_n = 1'b0; ref_mem[pa] = d; end
      else memory_read_n = 1'b0;
      #1;
      n_chk++; if (ram_address_select_n !== 1'b0) begin n_fail++; $display("FAIL rnd_sel %0d: got %b want 0", it, ram_address_select_n); end
      wait_ready(60, cyc, ok);
      n_chk++; if (!ok) begin n_fail++; $display("FAIL rnd_ready %0d: got timeout want ready", it); end
      if (!wr) begin
        n_chk++; if (data_bus_out !== ref_byte(pa)) begin n_fail++; $display("FAIL rnd_data %0d: got %h want %h", it, data_bus_out, ref_byte(pa)); end
      end
      memory_read_n = 1'b1; memory_write_n = 1'b1;
      wait_idle(60, ok);
      n_chk++;
      if (!ok || log_q.size() != 1) begin n_fail++; $display("FAIL rnd_count %0d: got ok=%0d requests=%0d want 1 1", it, ok, log_q.size()); end
      else if (log_q[0].wr != wr || log_q[0].addr !== pa[21:1] || log_q[0].be !== (pa[0] ? 2'b10 : 2'b01) || (wr && log_q[0].wd !== {d, d})) begin
        n_fail++; $display("FAIL rnd_req %0d: got wr=%0d addr=%h be=%b wd=%h want %0d %h %b %h", it, log_q[0].wr, log_q[0].addr, log_q[0].be, log_q[0].wd, wr, pa[21:1], pa[0] ? 2'b10 : 2'b01, {d, d}); end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clock);
    ctl_on = 1'b0; mem_ack = 1'b0; ems_enable = 1'b0;
    address = 20'h12345; memory_read_n = 1'b0;
    @(negedge clock);
    n_chk++; if (mem_read_req !== 1'b1) begin n_fail++; $display("FAIL rm_req: got %b want 1", mem_read_req); end
    reset = 1'b1;
    @(negedge clock);
    n_chk++; if ({mem_read_req, mem_write_req} !== 2'b00 || data_bus_out !== 8'h00) begin
      n_fail++; $display("FAIL rm_reset: got req=%b dout=%h want 00 00", {mem_read_req, mem_write_req}, data_bus_out); end
    reset = 1'b0; memory_read_n = 1'b1;
    @(negedge clock);
    mem_read_data = 16'hFFFF; mem_ack = 1'b1;
    @(negedge clock);
    mem_ack = 1'b0;
    n_chk++; if (data_bus_out !== 8'h00 || mem_read_req !== 1'b0) begin
      n_fail++; $display("FAIL rm_late_ack: got dout=%h req=%b want 00 0", data_bus_out, mem_read_req); end
    ctl_on = 1'b1;
  endtask

  initial begin
    reset = 1'b1; enable_sdram = 1'b1; address = '0; internal_data_bus = '0;
    memory_read_n = 1'b1; memory_write_n = 1'b1; ems_enable = 1'b0;
    ems_frame = 4'hD; map_ems = '0;
    np_rd_n = 1'b1; np_wr_n = 1'b1; np_ack = 1'b0; np_rdata = '0;
    test_reset();
    test_conventional_read();
    test_ems();
    test_reserved();
    test_posted_write();
    test_nonposted_write();
    test_abort();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
